// File: rtl/median_window_feeder.sv
// median_window_feeder
// Turns a raster pixel stream into aligned 3-row columns for a 3x3 median
// filter. Two LINE_WIDTH-deep delay lines (one shared pointer) provide the
// words delayed by one and two lines; the current word is the newest row.
// Optional build macro: MEDIAN_FEEDER_ZERO_PAD_EN -- when defined, columns
// are also emitted while the delay lines are still filling, with unfilled
// positions reading zero.
module median_window_feeder #(
    parameter int WIDTH       = 32,
    parameter int LINE_WIDTH  = 64,
    parameter int TOTAL_WORDS = 8533
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] src_out_data,
    input  logic             src_out_valid,
    output logic [WIDTH-1:0] row0_in_data,
    output logic [WIDTH-1:0] row1_in_data,
    output logic [WIDTH-1:0] row2_in_data,
    output logic             row_valid,
    output logic             valid
);

    localparam int CW   = $clog2(TOTAL_WORDS + 1);
    localparam int PW   = $clog2(LINE_WIDTH);
    localparam int FILL = 2 * LINE_WIDTH;

`ifdef MEDIAN_FEEDER_ZERO_PAD_EN
    localparam bit ZERO_PAD = 1'b1;
`else
    localparam bit ZERO_PAD = 1'b0;
`endif

    typedef enum logic [1:0] {
        PRIME  = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [31:0]       idx;
    logic              accept;
    logic              pulse;

    // tap 0: word delayed one line; tap 1: word delayed two lines
    logic [1:0][WIDTH-1:0] tap_wr;
    logic [1:0][WIDTH-1:0] tap_rd;

    logic [WIDTH-1:0] row0_q, row1_q, row2_q;
    logic             row_valid_q, valid_q;

    assign idx    = 32'(count_q);
    assign accept = src_out_valid && (state_q != DONE) && !rst;

    // Second line is fed by the output of the first, forming a 2-line cascade
    assign tap_wr[0] = src_out_data;
    assign tap_wr[1] = tap_rd[0];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_line
            logic [WIDTH-1:0] line_mem [LINE_WIDTH];
            logic [WIDTH-1:0] rd_q;

            // Block-RAM style line: write on accept, registered read of the
            // slot the next accepted word will use (prefetch via ptr_d).
            always_ff @(posedge clk) begin
                if (accept) begin
                    line_mem[ptr_q] <= tap_wr[gi];
                end
                rd_q <= line_mem[ptr_d];
            end

            assign tap_rd[gi] = rd_q;
        end
    endgenerate

    // Next-state logic: counter, shared ring pointer, phase and emit decision
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ptr_d   = ptr_q;
        pulse   = 1'b0;
        if (rst) begin
            state_d = PRIME;
            count_d = '0;
            ptr_d   = '0;
        end else if (accept) begin
            if (idx < 32'(TOTAL_WORDS)) begin
                count_d = count_q + 1'b1;
            end
            ptr_d = (ptr_q == PW'(LINE_WIDTH - 1)) ? '0 : ptr_q + 1'b1;
            pulse = ZERO_PAD || (idx >= 32'(FILL));
            if (idx + 32'd1 == 32'(TOTAL_WORDS)) begin
                state_d = DONE;
            end else if (idx + 32'd1 == 32'(FILL)) begin
                state_d = STREAM;
            end
        end
    end

    // State register for the phase FSM, word counter and ring pointer
    always_ff @(posedge clk) begin
        state_q <= state_d;
        count_q <= count_d;
        ptr_q   <= ptr_d;
    end

    // Registered column outputs; rows hold between pulses, done flag lags by one
    always_ff @(posedge clk) begin
        if (rst) begin
            row0_q      <= '0;
            row1_q      <= '0;
            row2_q      <= '0;
            row_valid_q <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            row_valid_q <= pulse;
            valid_q     <= (state_q == DONE);
            if (pulse) begin
                row2_q <= src_out_data;
                row1_q <= (idx < 32'(LINE_WIDTH)) ? '0 : tap_rd[0];
                row0_q <= (idx < 32'(FILL)) ? '0 : tap_rd[1];
            end
        end
    end

    assign row0_in_data = row0_q;
    assign row1_in_data = row1_q;
    assign row2_in_data = row2_q;
    assign row_valid    = row_valid_q;
    assign valid        = valid_q;

endmodule

// File: tb/tb_median_window_feeder.sv
// Scoreboard bench for median_window_feeder (LINE_WIDTH=4, TOTAL_WORDS=16).
module tb_median_window_feeder;

    localparam int W    = 32;
    localparam int L    = 4;
    localparam int T    = 16;
    localparam int FILL = 2 * L;

`ifdef MEDIAN_FEEDER_ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] src_out_data;
    logic         src_out_valid;
    logic [W-1:0] row0_in_data, row1_in_data, row2_in_data;
    logic         row_valid, valid;

    median_window_feeder #(
        .WIDTH(W), .LINE_WIDTH(L), .TOTAL_WORDS(T)
    ) dut (
        .clk(clk), .rst(rst),
        .src_out_data(src_out_data), .src_out_valid(src_out_valid),
        .row0_in_data(row0_in_data), .row1_in_data(row1_in_data),
        .row2_in_data(row2_in_data), .row_valid(row_valid), .valid(valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] r0, r1, r2;
        bit           last;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] hist[$];
    int           total = 0;
    int           bad = 0;
    int           m_count = 0;
    int           exp_pulses = 0;
    int           seen_pulses = 0;
    bit           mon_en = 1'b0;
    bit           exp_valid = 1'b0;
    bit           done_next = 1'b0;
    logic         rst_seen;
    logic [W-1:0] last0 = '0, last1 = '0, last2 = '0;

    always @(posedge clk) rst_seen <= rst;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a column
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (rst_seen === 1'b1) begin
                check("rst_row0", row0_in_data, '0);
                check("rst_row1", row1_in_data, '0);
                check("rst_row2", row2_in_data, '0);
                check("rst_row_valid", W'(row_valid), '0);
                check("rst_valid", W'(valid), '0);
                last0 = '0; last1 = '0; last2 = '0;
                exp_valid = 1'b0;
                done_next = 1'b0;
            end else begin
                if (done_next) begin
                    exp_valid = 1'b1;
                    done_next = 1'b0;
                end
                check("valid", W'(valid), W'(exp_valid));
                if (row_valid === 1'b1) begin
                    seen_pulses++;
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_pulse: got %0h/%0h/%0h want none at %0t",
                                 row0_in_data, row1_in_data, row2_in_data, $time);
                    end else begin
                        e = sb.pop_front();
                        check("row0", row0_in_data, e.r0);
                        check("row1", row1_in_data, e.r1);
                        check("row2", row2_in_data, e.r2);
                        if (e.last) done_next = 1'b1;
                    end
                    last0 = row0_in_data; last1 = row1_in_data; last2 = row2_in_data;
                end else begin
                    check("hold_row0", row0_in_data, last0);
                    check("hold_row1", row1_in_data, last1);
                    check("hold_row2", row2_in_data, last2);
                end
            end
        end
    end

    // Stimulus: drive one cycle and record the expected column from history
    task automatic send(input logic [W-1:0] d, input bit v);
        exp_t e;
        int   k;
        src_out_data  = d;
        src_out_valid = v;
        if (v && m_count < T) begin
            k = m_count;
            hist.push_back(d);
            e.r2   = d;
            e.r1   = (k >= L) ? hist[k-L] : '0;
            e.r0   = (k >= FILL) ? hist[k-FILL] : '0;
            e.last = (k == T - 1);
            if (PAD || k >= FILL) begin
                sb.push_back(e);
                exp_pulses++;
            end
            m_count++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        send('0, 1'b0);
        send('0, 1'b0);
        rst = 1'b1;
        sb.delete();
        hist.delete();
        m_count     = 0;
        exp_pulses  = 0;
        seen_pulses = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic end_phase(input string name);
        for (int i = 0; i < 5; i++) send('0, 1'b0);
        check({name, "_pulses"}, W'(seen_pulses), W'(exp_pulses));
        check({name, "_sb_empty"}, W'(sb.size()), '0);
    endtask

    initial begin
        rst           = 1'b1;
        src_out_data  = '0;
        src_out_valid = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        // contiguous 1..16
        for (int i = 1; i <= T; i++) send(W'(i), 1'b1);
        end_phase("contig");
        check("contig_done", W'(valid), W'(1));
        check("contig_npulses", W'(exp_pulses), PAD ? W'(16) : W'(8));

        // input after completion must be ignored
        for (int i = 0; i < 10; i++) send(32'hDEAD, 1'b1);
        end_phase("post_done");
        check("post_done_valid", W'(valid), W'(1));

        // bubble every other cycle
        do_reset();
        for (int i = 1; i <= T; i++) begin
            send(W'(i), 1'b1);
            send(32'hBAD0 + W'(i), 1'b0);
        end
        end_phase("bubbles");
        check("bubbles_done", W'(valid), W'(1));

        // reset mid-stream after word 6, then a fresh run
        do_reset();
        for (int i = 1; i <= 6; i++) send(W'(i), 1'b1);
        do_reset();
        for (int i = 101; i <= 100 + T; i++) send(W'(i), 1'b1);
        end_phase("midrst");
        check("midrst_done", W'(valid), W'(1));

        // randomized runs with random bubbles and lengths
        for (int r = 0; r < 8; r++) begin
            int n;
            do_reset();
            n = int'($urandom_range(3, 3 * T));
            for (int i = 0; i < n; i++) send($urandom, ($urandom_range(0, 2) != 0));
            end_phase("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/median_window_feeder.md
MEDIAN_WINDOW_FEEDER -- requirements
Module: median_window_feeder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: word width of every data port.
REQ-002 The block SHALL have parameter LINE_WIDTH, default 64: words per image line; legal range 2..1024.
REQ-003 The block SHALL have parameter TOTAL_WORDS, default 8533: input words accepted before completion.
REQ-004 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port src_out_data, input, WIDTH: pixel word from the upstream stream.
REQ-007 Port src_out_valid, input, 1: src_out_data is valid this cycle; no backpressure exists.
REQ-008 Port row0_in_data, output, WIDTH: oldest row word (input delayed 2*LINE_WIDTH accepted words).
REQ-009 Port row1_in_data, output, WIDTH: middle row word (input delayed LINE_WIDTH accepted words).
REQ-010 Port row2_in_data, output, WIDTH: newest row word (current accepted word).
REQ-011 Port row_valid, output, 1: row0/1/2 hold an aligned column this cycle.
REQ-012 Port valid, output, 1: sticky completion flag.

Function
REQ-013 A word SHALL be accepted on any cycle with src_out_valid=1, valid=0, rst=0.
REQ-014 Two LINE_WIDTH-deep delay lines SHALL shift only on accepted words; bubbles leave contents unchanged.
REQ-015 Row outputs SHALL be registered: an accepted word appears on row2_in_data exactly 1 cycle later with row_valid=1.
REQ-016 row_valid SHALL be 1 for exactly one cycle per qualifying accepted word and 0 otherwise; row outputs hold last values while row_valid=0.
REQ-017 An accepted-word counter (width ceil(log2(TOTAL_WORDS+1))) SHALL increment per accepted word and saturate at TOTAL_WORDS.
REQ-018 States SHALL be PRIME (accepted < 2*LINE_WIDTH), STREAM, DONE; PRIME->STREAM on the 2*LINE_WIDTH-th accepted word; any state->DONE on the TOTAL_WORDS-th accepted word.
REQ-019 In DONE, valid SHALL be 1 starting the cycle after the final word's row_valid pulse, and held until rst; further src_out_valid is ignored and row_valid stays 0.
REQ-020 If TOTAL_WORDS < 2*LINE_WIDTH, DONE SHALL be entered directly from PRIME.
REQ-021 Delay-line read/write pointers SHALL wrap from LINE_WIDTH-1 to 0 with no lost or duplicated word.

Reset
REQ-022 On rst=1 at a clock edge: row0/1/2_in_data=0, row_valid=0, valid=0, counter=0, pointers=0, state=PRIME.
REQ-023 Delay-line storage SHALL NOT require reset; stale contents SHALL never reach outputs while row_valid=1 (except zeros under REQ-025).
REQ-024 rst mid-stream SHALL discard all buffered words; the next accepted word is treated as word 0.

Configuration
REQ-025 With MEDIAN_FEEDER_ZERO_PAD_EN defined, row_valid SHALL also pulse during PRIME, with unfilled row0/row1 positions reading 0 (TOTAL_WORDS pulses total).
REQ-026 Without MEDIAN_FEEDER_ZERO_PAD_EN, row_valid SHALL stay 0 during PRIME (max(0, TOTAL_WORDS-2*LINE_WIDTH) pulses total).

Verification (LINE_WIDTH=4, TOTAL_WORDS=16)
REQ-027 Feed 1..16 contiguous, no macro -> first row_valid for word 9 with row0/1/2=1/5/9; last with 8/12/16; 8 pulses; valid=1 the next cycle.
REQ-028 Same stimulus, macro defined -> 16 pulses; word 1 gives 0/0/1, word 5 gives 0/1/5, word 9 gives 1/5/9.
REQ-029 Words 1..16 with src_out_valid low every other cycle -> identical row triples to REQ-027; no pulse on bubble cycles.
REQ-030 Assert rst after word 6, then feed 101..116 -> no 1..6 ever appears; first triple 101/105/109.
REQ-031 After valid=1, drive src_out_valid=1 with 0xDEAD for 10 cycles -> row_valid stays 0, outputs unchanged, valid stays 1.
